// File: rtl/ranger_pkg.sv
// Shared definitions for the ultrasonic ranger scheduler.
//   - FSM state encoding (also exported on state_dbg)
//   - result width, timeout sentinel and the result payload struct
//   - saturating scale helper used to turn an echo count into a result
package ranger_pkg;

  localparam int unsigned RESULT_W = 16;
  localparam int unsigned CNT_W    = 32;
  localparam int unsigned STATE_W  = 3;

  localparam logic [RESULT_W-1:0] RESULT_TIMEOUT = 16'hFFFF;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_TRIG_END  = 3'd2,
    ST_WAIT_ECHO = 3'd3,
    ST_MEASURE   = 3'd4,
    ST_DONE      = 3'd5,
    ST_HOLD      = 3'd6
  } state_e;

  typedef struct packed {
    logic                timeout;
    logic [RESULT_W-1:0] value;
  } meas_t;

  // Shift the echo count down and clamp it to the result range.
  function automatic logic [RESULT_W-1:0] sat_result(input logic [CNT_W-1:0] cnt,
                                                     input int unsigned      shift);
    logic [CNT_W-1:0] s;
    s = cnt >> shift;
    if (s > CNT_W'(RESULT_TIMEOUT)) return RESULT_TIMEOUT;
    return RESULT_W'(s);
  endfunction

endpackage

// File: rtl/ranger_sync.sv
// Two-flop synchronizer with registered rise/fall detection for an
// asynchronous single-bit sensor input.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   async_i      : raw asynchronous input
//   rise_o       : one-cycle pulse after the synchronized value rises
//   fall_o       : one-cycle pulse after the synchronized value falls
module ranger_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, dly_q, rise_q, fall_q;

  // meta_q/sync_q form the synchronizer; dly_q is the previous synced value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
      rise_q <= sync_q & ~dly_q;
      fall_q <= ~sync_q & dly_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ranger_sched.sv
// Time-multiplexes the single ultrasonic ranger line between FDU0 and FDU1:
// round-robin arbitration of level requests, trigger pulse, echo wait,
// echo width measurement, scaling, done pulse and settle holdoff.
// Optional build macro: RANGER_AVG_EN -- per-FDU running average of the
// last four non-timeout results.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   req[1:0]     : level request per FDU
//   health[1:0]  : watchdog health per FDU (unhealthy requesters never win)
//   usrs_in      : raw ranger line (asynchronous)
//   usrs_oe/out  : ranger line drive enable / driven value
//   grant[1:0]   : one-hot current owner, 00 when idle
//   busy         : high whenever not IDLE
//   done[1:0]    : one-cycle result-valid pulse to the owner
//   result/timeout : scaled echo width and its timeout qualifier (held)
//   state_dbg    : encoded FSM state
module ranger_sched
  import ranger_pkg::*;
#(
  parameter int unsigned TRIGGER_PULSE      = 250,
  parameter int unsigned ECHO_START_TIMEOUT = 50000,
  parameter int unsigned ECHO_MAX           = 1250000,
  parameter int unsigned HOLDOFF            = 500000,
  parameter int unsigned DIV_SHIFT          = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          req,
  input  logic [1:0]          health,
  input  logic                usrs_in,
  output logic                usrs_oe,
  output logic                usrs_out,
  output logic [1:0]          grant,
  output logic                busy,
  output logic [1:0]          done,
  output logic [RESULT_W-1:0] result,
  output logic                timeout,
  output logic [STATE_W-1:0]  state_dbg
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [1:0]          grant_q, grant_d;
  logic                last_q, last_d;
  meas_t               meas_q, meas_d;
  logic                oe_q, out_q, busy_q;
  logic [1:0]          done_q;
  logic [1:0]          eligible;
  logic                owner, owner_ok, pick;
  logic                echo_rise, echo_fall;
  logic [RESULT_W-1:0] scaled, sample;

  ranger_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (usrs_in),
    .rise_o  (echo_rise),
    .fall_o  (echo_fall)
  );

  assign eligible = req & health;
  assign owner    = grant_q[1];
  assign owner_ok = health[owner];
  assign cnt_inc  = cnt_q + 32'd1;
  // cnt_inc includes the cycle in which the fall is recognised, so it equals
  // the raw echo-high width.
  assign scaled   = sat_result(cnt_inc, DIV_SHIFT);

`ifdef RANGER_AVG_EN
  localparam int unsigned SUM_W = RESULT_W + 2;

  // Three most recent samples per FDU; the fourth term is the new sample.
  logic [RESULT_W-1:0] hist_q [2][3];
  logic [SUM_W-1:0]    hist_sum;
  logic                hist_push;

  assign hist_push = (state_q == ST_MEASURE) && owner_ok && echo_fall;
  assign hist_sum  = SUM_W'(scaled) + SUM_W'(hist_q[owner][0])
                   + SUM_W'(hist_q[owner][1]) + SUM_W'(hist_q[owner][2]);
  assign sample    = RESULT_W'(hist_sum >> 2);

  // Shift the new non-timeout sample into the owner's history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < 3; j++) begin
          hist_q[i][j] <= '0;
        end
      end
    end else if (hist_push) begin
      hist_q[owner][2] <= hist_q[owner][1];
      hist_q[owner][1] <= hist_q[owner][0];
      hist_q[owner][0] <= scaled;
    end
  end
`else
  assign sample = scaled;
`endif

  // State and output registers; outputs are decoded from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      meas_q  <= '0;
      oe_q    <= 1'b0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      meas_q  <= meas_d;
      oe_q    <= (state_d == ST_TRIG) || (state_d == ST_TRIG_END);
      out_q   <= (state_d == ST_TRIG);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE) ? grant_q : 2'b00;
    end
  end

  // Next-state, arbitration and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    grant_d = grant_q;
    last_d  = last_q;
    meas_d  = meas_q;
    pick    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (eligible != 2'b00) begin
          pick    = (eligible == 2'b11) ? ~last_q : eligible[1];
          grant_d = pick ? 2'b10 : 2'b01;
          last_d  = pick;
          state_d = ST_TRIG;
        end
      end
      ST_TRIG: begin
        if (!owner_ok) begin
          state_d = ST_HOLD;
        end else if (cnt_inc == CNT_W'(TRIGGER_PULSE)) begin
          state_d = ST_TRIG_END;
        end
      end
      ST_TRIG_END: begin
        state_d = owner_ok ? ST_WAIT_ECHO : ST_HOLD;
      end
      ST_WAIT_ECHO: begin
        if (!owner_ok) begin
          state_d = ST_HOLD;
        end else if (echo_rise) begin
          state_d = ST_MEASURE;
        end else if (cnt_inc == CNT_W'(ECHO_START_TIMEOUT)) begin
          meas_d.timeout = 1'b1;
          meas_d.value   = RESULT_TIMEOUT;
          state_d        = ST_DONE;
        end
      end
      ST_MEASURE: begin
        if (!owner_ok) begin
          state_d = ST_HOLD;
        end else if (echo_fall) begin
          meas_d.timeout = 1'b0;
          meas_d.value   = sample;
          state_d        = ST_DONE;
        end else if (cnt_inc == CNT_W'(ECHO_MAX)) begin
          meas_d.timeout = 1'b1;
          meas_d.value   = RESULT_TIMEOUT;
          state_d        = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt_inc == CNT_W'(HOLDOFF)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The line owner is released on any entry into HOLD (normal or abort).
    if (state_d == ST_HOLD) grant_d = 2'b00;
    if (state_d != state_q) cnt_d = '0;
  end

  assign usrs_oe   = oe_q;
  assign usrs_out  = out_q;
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = meas_q.value;
  assign timeout   = meas_q.timeout;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ranger_sched.sv
// Bench for ranger_sched. A cycle timeline of stimulus and expected outputs
// is planned up front from transaction-level rules (grant time, trigger
// window, echo timing, done time, holdoff), then replayed against the DUT.
module tb_ranger_sched;

  localparam int TP   = 10;
  localparam int EST  = 100;
  localparam int EMAX = 1000;
  localparam int HO   = 20;
  localparam int DS   = 4;
  localparam int NCYC = 2000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req, health;
  logic        usrs_in;
  logic        usrs_oe, usrs_out, busy, timeout;
  logic [1:0]  grant, done;
  logic [15:0] result;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit run    = 1'b0;

  // Stimulus timeline
  logic [1:0]  req_a [NCYC];
  logic [1:0]  hlt_a [NCYC];
  logic        echo_a[NCYC];
  // Expected-output timeline
  logic [1:0]  xg [NCYC];
  logic [1:0]  xd [NCYC];
  logic        xb [NCYC];
  logic        xoe[NCYC];
  logic        xout[NCYC];
  logic [15:0] xres[NCYC];
  logic        xto[NCYC];

`ifdef RANGER_AVG_EN
  int hist[2][3];
`endif

  always #5 clk = ~clk;

  ranger_sched #(
    .TRIGGER_PULSE      (TP),
    .ECHO_START_TIMEOUT (EST),
    .ECHO_MAX           (EMAX),
    .HOLDOFF            (HO),
    .DIV_SHIFT          (DS)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .health    (health),
    .usrs_in   (usrs_in),
    .usrs_oe   (usrs_oe),
    .usrs_out  (usrs_out),
    .grant     (grant),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .timeout   (timeout),
    .state_dbg (state_dbg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] onehot(input int owner);
    return (owner == 1) ? 2'b10 : 2'b01;
  endfunction

  // Result an FDU should see for an echo of w raw cycles.
  function automatic logic [15:0] model_scale(input int owner, input int w);
    int sc;
    sc = w >> DS;
    if (sc > 65535) sc = 65535;
`ifdef RANGER_AVG_EN
    begin
      int s;
      s = sc + hist[owner][0] + hist[owner][1] + hist[owner][2];
      hist[owner][2] = hist[owner][1];
      hist[owner][1] = hist[owner][0];
      hist[owner][0] = sc;
      sc = s >> 2;
    end
`endif
    return 16'(sc);
  endfunction

  task automatic set_req(input int from, input int to, input logic [1:0] v);
    for (int c = from; c <= to && c < NCYC; c++) req_a[c] = req_a[c] | v;
  endtask

  task automatic drop_health(input int from, input int to, input logic [1:0] m);
    for (int c = from; c <= to && c < NCYC; c++) hlt_a[c] = hlt_a[c] & ~m;
  endtask

  task automatic fill_echo(input int e, input int w);
    for (int c = e; c < e + w && c < NCYC; c++) echo_a[c] = 1'b1;
  endtask

  // Completed transaction granted at cycle g. w==0 means no echo at all;
  // otherwise the raw echo rises dly cycles after the trigger falls.
  task automatic plan_txn(input int owner, input int g, input int dly, input int w,
                          output int d);
    int          rel, e;
    logic [15:0] r;
    logic        to;
    rel = g + TP;
    for (int c = g; c < rel; c++) begin xoe[c] = 1'b1; xout[c] = 1'b1; end
    xoe[rel] = 1'b1;
    if (w == 0) begin
      d  = rel + 1 + EST;
      r  = 16'hFFFF;
      to = 1'b1;
    end else begin
      e = rel + dly;
      fill_echo(e, w);
      if (w > EMAX) begin
        d  = e + 4 + EMAX;
        r  = 16'hFFFF;
        to = 1'b1;
      end else begin
        d  = e + w + 4;
        r  = model_scale(owner, w);
        to = 1'b0;
      end
    end
    for (int c = g; c <= d && c < NCYC; c++) xg[c] = onehot(owner);
    for (int c = g; c <= d + HO && c < NCYC; c++) xb[c] = 1'b1;
    if (d < NCYC) xd[d] = onehot(owner);
    for (int c = d; c < NCYC; c++) begin xres[c] = r; xto[c] = to; end
  endtask

  // Transaction granted at g whose owner loses health in cycle h.
  task automatic plan_abort(input int owner, input int g, input int h);
    for (int c = g; c <= h; c++) xg[c] = onehot(owner);
    for (int c = g; c <= h + HO && c < NCYC; c++) xb[c] = 1'b1;
    for (int c = g; c <= h && c <= g + TP; c++) xoe[c] = 1'b1;
    for (int c = g; c <= h && c < g + TP; c++) xout[c] = 1'b1;
  endtask

  // Per-cycle comparison against the planned timeline plus pinned literals.
  always @(negedge clk) begin
    logic [31:0] exp_v, act_v;
    if (run) begin
      exp_v = 32'({xg[cyc], xd[cyc], xb[cyc], xoe[cyc], xout[cyc], xto[cyc], xres[cyc]});
      act_v = 32'({grant, done, busy, usrs_oe, usrs_out, timeout, result});
      chk($sformatf("cycle%0d_outputs", cyc), act_v, exp_v);
      chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      case (cyc)
        6:    begin chk("c2_grant1", 32'(grant), 32'h1); chk("c2_state_trig", 32'(state_dbg), 32'd1); end
        57:   begin
                chk("c2_done1", 32'(done), 32'h1);
`ifndef RANGER_AVG_EN
                chk("c2_result1", 32'(result), 32'd2);
`endif
              end
        79:   chk("c2_grant2", 32'(grant), 32'h2);
        162:  chk("c2_done2", 32'(done), 32'h2);
        184:  chk("c2_grant3", 32'(grant), 32'h1);
        299:  chk("c2_done3", 32'(done), 32'h1);
        340:  chk("t1_trig_last", 32'(usrs_out), 32'd1);
        341:  begin
                chk("t1_trig_end_out", 32'({usrs_oe, usrs_out}), 32'h2);
                chk("t1_state_trig_end", 32'(state_dbg), 32'd2);
              end
        342:  begin
                chk("t1_released", 32'(usrs_oe), 32'd0);
                chk("t1_state_wait", 32'(state_dbg), 32'd3);
              end
        400:  chk("t1_state_measure", 32'(state_dbg), 32'd4);
        510:  begin
                chk("t1_done", 32'(done), 32'h1);
                chk("t1_timeout", 32'(timeout), 32'd0);
                chk("t1_state_done", 32'(state_dbg), 32'd5);
`ifndef RANGER_AVG_EN
                chk("t1_result", 32'(result), 32'd10);
`endif
              end
        530:  chk("t1_busy_hold_end", 32'(busy), 32'd1);
        531:  chk("t1_busy_idle", 32'(busy), 32'd0);
        652:  chk("t3_noecho", 32'({done, timeout, result}), 32'h5FFFF);
        1700: chk("t4_stuck", 32'({done, timeout, result}), 32'h3FFFF);
        1851: begin
                chk("t5_abort_grant", 32'({grant, usrs_oe, busy}), 32'h1);
                chk("t5_state_hold", 32'(state_dbg), 32'd6);
                chk("t5_result_kept", 32'({timeout, result}), 32'h1FFFF);
              end
        1871: chk("t5_busy_idle", 32'(busy), 32'd0);
        1905: chk("t5b_trig_on", 32'(usrs_oe), 32'd1);
        1906: chk("t5b_trig_released", 32'(usrs_oe), 32'd0);
        1980: chk("t5c_unhealthy_ignored", 32'(grant), 32'h0);
        default: ;
      endcase
    end
  end

  initial begin
    int  d, g;
    bit  found;

    for (int c = 0; c < NCYC; c++) begin
      req_a[c] = 2'b00; hlt_a[c] = 2'b11; echo_a[c] = 1'b0;
      xg[c] = 2'b00; xd[c] = 2'b00; xb[c] = 1'b0; xoe[c] = 1'b0;
      xout[c] = 1'b0; xres[c] = 16'h0; xto[c] = 1'b0;
    end
`ifdef RANGER_AVG_EN
    for (int i = 0; i < 2; i++) for (int j = 0; j < 3; j++) hist[i][j] = 0;
`endif

    // Contention: both request continuously, grants alternate 0,1,0.
    plan_txn(0, 6, 5, 32, d);
    g = d + HO + 2; plan_txn(1, g, 5, 64, d);
    g = d + HO + 2; plan_txn(0, g, 5, 96, d);
    set_req(5, d, 2'b11);
    // Single request, 160-cycle echo.
    plan_txn(0, 331, 5, 160, d); set_req(330, d, 2'b01);
    // No echo.
    plan_txn(1, 541, 0, 0, d);   set_req(540, d, 2'b10);
    // Stuck echo.
    plan_txn(0, 681, 5, 1100, d); set_req(680, d, 2'b01);
    // Health drop during MEASURE.
    set_req(1810, 1851, 2'b01); drop_health(1850, 1855, 2'b01);
    fill_echo(1826, 60); plan_abort(0, 1811, 1850);
    // Health drop during TRIG.
    set_req(1900, 1906, 2'b10); drop_health(1905, 1910, 2'b10);
    plan_abort(1, 1901, 1905);
    // Requester with low health is never granted.
    set_req(1930, 1980, 2'b01); drop_health(1930, 1985, 2'b01);

    req = 2'b00; health = 2'b11; usrs_in = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    chk("reset_outputs", 32'({grant, done, busy, usrs_oe, usrs_out, timeout, result}), 32'h0);
    chk("reset_state", 32'(state_dbg), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      cyc     = c;
      req     = req_a[c];
      health  = hlt_a[c];
      usrs_in = echo_a[c];
      run     = 1'b1;
    end
    @(posedge clk);
    #1 run = 1'b0;

    // Asynchronous reset in the middle of a trigger pulse.
    req = 2'b01; health = 2'b11; usrs_in = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(posedge clk);
      #1;
      if (usrs_oe) found = 1'b1;
    end
    chk("mid_trig_started", 32'(found), 32'd1);
    repeat (3) @(posedge clk);
    #2;
    chk("mid_trig_driving", 32'({usrs_oe, usrs_out}), 32'h3);
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({grant, done, busy, usrs_oe, usrs_out, timeout, result}), 32'h0);
    chk("async_reset_state", 32'(state_dbg), 32'd0);
    req = 2'b00;
    #10 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
